keyboard: RTL and testbench



---
 rtl/keyboard_pkg.sv | 95 +++++++++
 rtl/keyboard_ps2_rx.sv | 103 ++++++++++
 rtl/keyboard.sv | 113 +++++++++++
 tb/tb_keyboard.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared constants, types and the set-2 scan-code lookup for the PS/2 keyboard.
// Imported by the frame receiver and the decoder.
package keyboard_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'h0,
        CLS_DIGIT  = 4'h1,
        CLS_LETTER = 4'h2,
        CLS_PUNCT  = 4'h3,
        CLS_CTRL   = 4'h4,
        CLS_MOD    = 4'h5
    } key_class_t;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // base = unshifted character, alt = shifted (or uppercase) character
    typedef struct packed {
        key_class_t kind;
        logic [7:0] base;
        logic [7:0] alt;
    } key_t;

    function automatic key_t lookup(input logic [7:0] sc);
        key_t k;
        k = '{CLS_NONE, 8'h00, 8'h00};
        case (sc)
            8'h1C: k = '{CLS_LETTER, 8'h61, 8'h41};
            8'h32: k = '{CLS_LETTER, 8'h62, 8'h42};
            8'h21: k = '{CLS_LETTER, 8'h63, 8'h43};
            8'h23: k = '{CLS_LETTER, 8'h64, 8'h44};
            8'h24: k = '{CLS_LETTER, 8'h65, 8'h45};
            8'h2B: k = '{CLS_LETTER, 8'h66, 8'h46};
            8'h34: k = '{CLS_LETTER, 8'h67, 8'h47};
            8'h33: k = '{CLS_LETTER, 8'h68, 8'h48};
            8'h43: k = '{CLS_LETTER, 8'h69, 8'h49};
            8'h3B: k = '{CLS_LETTER, 8'h6A, 8'h4A};
            8'h42: k = '{CLS_LETTER, 8'h6B, 8'h4B};
            8'h4B: k = '{CLS_LETTER, 8'h6C, 8'h4C};
            8'h3A: k = '{CLS_LETTER, 8'h6D, 8'h4D};
            8'h31: k = '{CLS_LETTER, 8'h6E, 8'h4E};
            8'h44: k = '{CLS_LETTER, 8'h6F, 8'h4F};
            8'h4D: k = '{CLS_LETTER, 8'h70, 8'h50};
            8'h15: k = '{CLS_LETTER, 8'h71, 8'h51};
            8'h2D: k = '{CLS_LETTER, 8'h72, 8'h52};
            8'h1B: k = '{CLS_LETTER, 8'h73, 8'h53};
            8'h2C: k = '{CLS_LETTER, 8'h74, 8'h54};
            8'h3C: k = '{CLS_LETTER, 8'h75, 8'h55};
            8'h2A: k = '{CLS_LETTER, 8'h76, 8'h56};
            8'h1D: k = '{CLS_LETTER, 8'h77, 8'h57};
            8'h22: k = '{CLS_LETTER, 8'h78, 8'h58};
            8'h35: k = '{CLS_LETTER, 8'h79, 8'h59};
            8'h1A: k = '{CLS_LETTER, 8'h7A, 8'h5A};
            8'h16: k = '{CLS_DIGIT, 8'h31, 8'h21};
            8'h1E: k = '{CLS_DIGIT, 8'h32, 8'h40};
            8'h26: k = '{CLS_DIGIT, 8'h33, 8'h23};
            8'h25: k = '{CLS_DIGIT, 8'h34, 8'h24};
            8'h2E: k = '{CLS_DIGIT, 8'h35, 8'h25};
            8'h36: k = '{CLS_DIGIT, 8'h36, 8'h5E};
            8'h3D: k = '{CLS_DIGIT, 8'h37, 8'h26};
            8'h3E: k = '{CLS_DIGIT, 8'h38, 8'h2A};
            8'h46: k = '{CLS_DIGIT, 8'h39, 8'h28};
            8'h45: k = '{CLS_DIGIT, 8'h30, 8'h29};
            8'h0E: k = '{CLS_PUNCT, 8'h60, 8'h7E};
            8'h4E: k = '{CLS_PUNCT, 8'h2D, 8'h5F};
            8'h55: k = '{CLS_PUNCT, 8'h3D, 8'h2B};
            8'h54: k = '{CLS_PUNCT, 8'h5B, 8'h7B};
            8'h5B: k = '{CLS_PUNCT, 8'h5D, 8'h7D};
            8'h5D: k = '{CLS_PUNCT, 8'h5C, 8'h7C};
            8'h4C: k = '{CLS_PUNCT, 8'h3B, 8'h3A};
            8'h52: k = '{CLS_PUNCT, 8'h27, 8'h22};
            8'h41: k = '{CLS_PUNCT, 8'h2C, 8'h3C};
            8'h49: k = '{CLS_PUNCT, 8'h2E, 8'h3E};
            8'h4A: k = '{CLS_PUNCT, 8'h2F, 8'h3F};
            8'h5A: k = '{CLS_CTRL, 8'h0D, 8'h0D};
            8'h29: k = '{CLS_CTRL, 8'h20, 8'h20};
            8'h66: k = '{CLS_CTRL, 8'h08, 8'h08};
            8'h0D: k = '{CLS_CTRL, 8'h09, 8'h09};
            8'h76: k = '{CLS_CTRL, 8'h1B, 8'h1B};
            default: k = '{CLS_NONE, 8'h00, 8'h00};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keyboard_ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizers, clock glitch filter,
// falling-edge detect, 11-bit frame FSM with odd parity check and timeout.
module ps2_rx
    import keyboard_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic [7:0] rx_byte,
    output logic       rx_done
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
    logic          filt, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic          fall, timeout;
    rx_state_t     state, state_n;

    // Lines idle high, so synchronizers and filter preset to 1.
    // NOTE: every register here is a flop updated with <=, so all reads in this
    // block see the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1   <= 1'b1;
            ps2c_s2   <= 1'b1;
            ps2d_s1   <= 1'b1;
            ps2d_s2   <= 1'b1;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            ps2c_s1   <= ps2c;
            ps2c_s2   <= ps2c_s1;
            ps2d_s1   <= ps2d;
            ps2d_s2   <= ps2d_s1;
            filt_prev <= filt;
            if (ps2c_s2 == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt     <= ps2c_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall    = filt_prev & ~filt;
    assign timeout = (state != RX_IDLE) && (timer == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: state_n gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            RX_IDLE:   if (fall && !ps2d_s2) state_n = RX_DATA;
            RX_DATA:   if (fall && bit_cnt == 3'd7) state_n = RX_PARITY;
            RX_PARITY: if (fall) state_n = RX_STOP;
            RX_STOP:   if (fall) state_n = RX_IDLE;
            default:   state_n = RX_IDLE;
        endcase
        if (timeout) state_n = RX_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RX_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
        end else begin
            state <= state_n;
            timer <= (state == RX_IDLE || fall) ? '0 : timer + 1'b1;
            if (fall) begin
                case (state)
                    RX_IDLE:   bit_cnt <= '0;
                    RX_DATA: begin
                        shreg   <= {ps2d_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    RX_PARITY: par <= ps2d_s2;
                    default:   ;
                endcase
            end
        end
    end

    assign rx_byte = shreg;
    assign rx_done = fall && (state == RX_STOP) && ps2d_s2 && (^{shreg, par});

endmodule

// File: rtl/keyboard.sv
// PS/2 keyboard decoder: tracks shift/caps-lock/break/extended state over
// received scan codes and publishes make codes as ASCII plus a key class.
module keyboard
    import keyboard_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic [7:0] scan_code,
    output logic       scan_code_ready,
    output logic [7:0] ascii_code,
    output logic       letter_case_out,
    output logic [3:0] code
);

    logic [7:0] rx_byte;
    logic       rx_done;
    logic       shift, caps, brk, ext;
    logic       shift_n, caps_n, brk_n, ext_n;
    logic       make, modifier, is_shift;
    key_t       key;
    logic [7:0] lut_ascii;
    key_class_t lut_class;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .ps2d    (ps2d),
        .ps2c    (ps2c),
        .rx_byte (rx_byte),
        .rx_done (rx_done)
    );

    assign is_shift = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);
    assign key      = lookup(rx_byte);

    // Letters follow shift XOR caps; everything else follows shift alone.
    always_comb begin
        lut_class = key.kind;
        if (key.kind == CLS_LETTER)
            lut_ascii = letter_case_out ? key.alt : key.base;
        else
            lut_ascii = shift ? key.alt : key.base;
        if (key.kind == CLS_DIGIT && shift)
            lut_class = CLS_PUNCT;
    end

    // Prefix bytes only set flags; extended keys decode as their base code.
    always_comb begin
        shift_n  = shift;
        caps_n   = caps;
        brk_n    = brk;
        ext_n    = ext;
        make     = 1'b0;
        modifier = 1'b0;
        if (rx_done) begin
            if (rx_byte == SC_EXT) begin
                ext_n = 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                brk_n = 1'b1;
            end else begin
                ext_n = 1'b0;
                brk_n = 1'b0;
                if (brk) begin
                    if (is_shift) shift_n = 1'b0;
                end else begin
                    make = 1'b1;
                    if (is_shift) begin
                        shift_n  = 1'b1;
                        modifier = 1'b1;
                    end else if (rx_byte == SC_CAPS) begin
                        caps_n   = ~caps;
                        modifier = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift           <= 1'b0;
            caps            <= 1'b0;
            brk             <= 1'b0;
            ext             <= 1'b0;
            letter_case_out <= 1'b0;
            scan_code_ready <= 1'b0;
            scan_code       <= '0;
            ascii_code      <= '0;
            code            <= CLS_NONE;
        end else begin
            shift           <= shift_n;
            caps            <= caps_n;
            brk             <= brk_n;
            ext             <= ext_n;
            letter_case_out <= shift_n ^ caps_n;
            scan_code_ready <= make;
            if (make) begin
                scan_code  <= rx_byte;
                ascii_code <= modifier ? 8'h00 : lut_ascii;
                code       <= modifier ? CLS_MOD : lut_class;
            end
        end
    end

endmodule

// File: tb/tb_keyboard.sv
// Directed self-checking bench for keyboard: bit-bangs PS/2 frames and checks
// decoded outputs and ready-pulse counts against hand-computed values.
module tb_keyboard;

    localparam int HALF = 30;
    localparam int TMO  = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic [7:0] ascii_code;
    logic       letter_case_out;
    logic [3:0] code;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int mark    = 0;

    keyboard #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2d            (ps2d),
        .ps2c            (ps2c),
        .scan_code       (scan_code),
        .scan_code_ready (scan_code_ready),
        .ascii_code      (ascii_code),
        .letter_case_out (letter_case_out),
        .code            (code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (scan_code_ready) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Sends the first nbits of an 11-bit frame; odd parity unless bad_par.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] frame;
        frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = frame[i];
            wait_clk(HALF);
            ps2c = 1'b0;
            wait_clk(HALF);
            ps2c = 1'b1;
        end
        wait_clk(HALF);
        ps2d = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic check_key(input string tag, input int dp, input logic [7:0] sc,
                             input logic [7:0] asc, input logic [3:0] cd);
        check({tag, " pulses"}, pulses - mark, dp);
        check({tag, " scan_code"}, scan_code, sc);
        check({tag, " ascii"}, ascii_code, asc);
        check({tag, " code"}, code, cd);
        mark = pulses;
    endtask

    initial begin
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2);
        check_key("reset", 0, 8'h00, 8'h00, 4'h0);
        check("reset case", letter_case_out, 0);

        send(8'h1C);
        check_key("a", 1, 8'h1C, 8'h61, 4'h2);
        check("a case", letter_case_out, 0);

        send(8'h12);
        check_key("shift make", 1, 8'h12, 8'h00, 4'h5);
        check("shift case", letter_case_out, 1);
        send(8'h32);
        check_key("B", 1, 8'h32, 8'h42, 4'h2);
        send(8'hF0); send(8'h12);
        check_key("shift break", 0, 8'h32, 8'h42, 4'h2);
        check("unshift case", letter_case_out, 0);
        send(8'h32);
        check_key("b", 1, 8'h32, 8'h62, 4'h2);

        send(8'h58);
        check_key("caps on", 1, 8'h58, 8'h00, 4'h5);
        check("caps case", letter_case_out, 1);
        send(8'h16);
        check_key("1 caps", 1, 8'h16, 8'h31, 4'h1);
        send(8'h58);
        check("caps off case", letter_case_out, 0);
        mark = pulses;

        send(8'hF0); send(8'h1C);
        check_key("release a", 0, 8'h58, 8'h00, 4'h5);

        send_frame(8'h1C, 1'b1, 1'b0, 11);
        check_key("bad parity", 0, 8'h58, 8'h00, 4'h5);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check_key("bad stop", 0, 8'h58, 8'h00, 4'h5);
        send(8'h5A);
        check_key("enter", 1, 8'h5A, 8'h0D, 4'h4);

        send_frame(8'h1C, 1'b0, 1'b0, 5);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(HALF);
        check_key("mid reset", 0, 8'h00, 8'h00, 4'h0);
        send(8'h29);
        check_key("space", 1, 8'h29, 8'h20, 4'h4);

        send_frame(8'h55, 1'b0, 1'b0, 4);
        wait_clk(TMO + 500);
        send(8'h16);
        check_key("after timeout", 1, 8'h16, 8'h31, 4'h1);

        send(8'h12);
        mark = pulses;
        send(8'h1E);
        check("at sign", ascii_code, 8'h40);
        mark = pulses;
        send(8'h4A);
        check_key("question", 1, 8'h4A, 8'h3F, 4'h3);
        send(8'hF0); send(8'h12);
        send(8'h4A);
        check_key("slash", 1, 8'h4A, 8'h2F, 4'h3);

        send(8'h05);
        check_key("unmapped", 1, 8'h05, 8'h00, 4'h0);
        send(8'hE0); send(8'h5A);
        check_key("ext enter", 1, 8'h5A, 8'h0D, 4'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
